// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, pixel type, phase encoding and colour-bar table for lcd_timing_gen.
package lcd_timing_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int H_FP_DEF     = 2;
  localparam int H_SYNC_DEF   = 41;
  localparam int H_BP_DEF     = 2;
  localparam int V_ACTIVE_DEF = 272;
  localparam int V_FP_DEF     = 2;
  localparam int V_SYNC_DEF   = 10;
  localparam int V_BP_DEF     = 2;
  localparam int CNT_W_DEF    = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return rgb565_t'(BAR_WHITE);
      3'd1:    return rgb565_t'(BAR_YELLOW);
      3'd2:    return rgb565_t'(BAR_CYAN);
      3'd3:    return rgb565_t'(BAR_GREEN);
      3'd4:    return rgb565_t'(BAR_MAGENTA);
      3'd5:    return rgb565_t'(BAR_RED);
      3'd6:    return rgb565_t'(BAR_BLUE);
      default: return rgb565_t'(BAR_BLACK);
    endcase
  endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One display axis: position counter plus phase FSM (ACTIVE -> FRONT -> SYNC -> BACK),
// each phase timed by a down-counter that hands over when it reaches zero.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int ACTIVE = 480,
  parameter int FP     = 2,
  parameter int SYNC   = 41,
  parameter int BP     = 2,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output phase_e           phase,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem_q;
  phase_e           phase_q;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_ACTIVE: return PH_FRONT;
      PH_FRONT:  return PH_SYNC;
      PH_SYNC:   return PH_BACK;
      default:   return PH_ACTIVE;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] phase_len_m1(input phase_e ph);
    case (ph)
      PH_ACTIVE: return CNT_W'(ACTIVE - 1);
      PH_FRONT:  return CNT_W'(FP - 1);
      PH_SYNC:   return CNT_W'(SYNC - 1);
      default:   return CNT_W'(BP - 1);
    endcase
  endfunction

  assign wrap  = step && (cnt_q == LAST);
  assign cnt   = cnt_q;
  assign phase = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= PH_ACTIVE;
      rem_q   <= phase_len_m1(PH_ACTIVE);
    end else if (clear) begin
      cnt_q   <= '0;
      phase_q <= PH_ACTIVE;
      rem_q   <= phase_len_m1(PH_ACTIVE);
    end else if (step) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      // BACK always expires on the last count, so the phase FSM stays locked to cnt
      if (rem_q == '0) begin
        phase_q <= next_phase(phase_q);
        rem_q   <= phase_len_m1(next_phase(phase_q));
      end else begin
        rem_q <= rem_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator: fetch requests (stage 1) and DE/syncs/RGB at the pins (stage 2).
// Define LCD_TEST_PATTERN_EN to replace pix_data with eight vertical colour bars.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = CNT_W_DEF
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  input  logic [15:0]      pix_data,
  output logic             lcd_de,
  output logic             lcd_hsync,
  output logic             lcd_vsync,
  output logic [4:0]       lcd_r,
  output logic [5:0]       lcd_g,
  output logic [4:0]       lcd_b
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_e           h_phase, v_phase;
  logic             h_wrap, v_wrap_unused;

  lcd_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk   (pixel_clk),
    .rst_n (rst_n),
    .step  (en),
    .clear (!en),
    .cnt   (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  lcd_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk   (pixel_clk),
    .rst_n (rst_n),
    .step  (h_wrap),
    .clear (!en),
    .cnt   (v_cnt),
    .phase (v_phase),
    .wrap  (v_wrap_unused)
  );

  logic pix_req_d, frame_start_d, hs1_d, vs1_d;
  logic pix_req_q, frame_start_q, hs1_q, vs1_q;
  logic [CNT_W-1:0] pix_x_q, pix_y_q;
  logic req2_q, hs2_q, vs2_q;
  logic de_q, hsync_q, vsync_q;
  rgb565_t rgb_q;
  rgb565_t rgb_src;

  assign pix_req_d     = en && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign frame_start_d = en && (h_cnt == '0) && (v_cnt == '0);
  assign hs1_d         = en && (h_phase == PH_SYNC);
  assign vs1_d         = en && (v_phase == PH_SYNC);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req_q     <= 1'b0;
      frame_start_q <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
    end else begin
      pix_req_q     <= pix_req_d;
      frame_start_q <= frame_start_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      if (pix_req_d) begin
        pix_x_q <= h_cnt;
        pix_y_q <= v_cnt;
      end
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [15:0] pix_data_unused;
  rgb565_t     bar_q;

  function automatic logic [2:0] bar_idx(input logic [CNT_W-1:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x) >= i * BAR_W) idx = 3'(i);
    end
    return idx;
  endfunction

  assign pix_data_unused = pix_data;
  assign rgb_src         = bar_q;

  // The bar colour takes the same slot the upstream read would, keeping RGB aligned with DE
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) bar_q <= '0;
    else        bar_q <= bar_colour(bar_idx(pix_x_q));
  end
`else
  assign rgb_src = rgb565_t'(pix_data);
`endif

  // Middle stage is gated by en so dropping en flushes the in-flight pixel
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      req2_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      rgb_q   <= '0;
    end else begin
      req2_q  <= en && pix_req_q;
      hs2_q   <= en && hs1_q;
      vs2_q   <= en && vs1_q;
      de_q    <= req2_q;
      hsync_q <= hs2_q ? HS_POL : ~HS_POL;
      vsync_q <= vs2_q ? VS_POL : ~VS_POL;
      rgb_q   <= req2_q ? rgb_src : '0;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign lcd_de      = de_q;
  assign lcd_hsync   = hsync_q;
  assign lcd_vsync   = vsync_q;
  assign lcd_r       = rgb_q.r;
  assign lcd_g       = rgb_q.g;
  assign lcd_b       = rgb_q.b;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: default 480x272 instance plus a tiny instance with
// inverted sync polarity for whole-frame vertical timing.
module tb_lcd_timing_gen;

  localparam int HT     = 525;
  localparam int VT     = 286;
  localparam int DROP_T = 100 * HT + 200;

`ifdef LCD_TEST_PATTERN_EN
  localparam logic [15:0] RGB00 = 16'hFFFF;
  localparam logic [15:0] P0    = 16'hFFFF;
  localparam logic [15:0] P60   = 16'hFFE0;
  localparam logic [15:0] P420  = 16'h0000;
`else
  localparam logic [15:0] RGB00 = 16'h0000;
  localparam logic [15:0] P0    = 16'h0001;
  localparam logic [15:0] P60   = 16'hF001;
  localparam logic [15:0] P420  = 16'h9001;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  logic en_s  = 1'b0;
  logic [15:0] pix_data   = 16'h0;
  logic [15:0] pix_data_s = 16'h0;
  logic [15:0] pd_next    = 16'h0;

  logic       pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync;
  logic [9:0] pix_x, pix_y;
  logic [4:0] lcd_r, lcd_b;
  logic [5:0] lcd_g;
  logic [15:0] rgb;

  logic       s_req, s_fs, s_de, s_hs, s_vs;
  logic [3:0] s_x, s_y;
  logic [4:0] s_r, s_b;
  logic [5:0] s_g;

  int checks = 0;
  int errors = 0;

  assign rgb = {lcd_r, lcd_g, lcd_b};

  always #5 clk = ~clk;

  lcd_timing_gen u_dut (
    .pixel_clk(clk), .rst_n(rst_n), .en(en),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .pix_data(pix_data),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
  );

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) u_small (
    .pixel_clk(clk), .rst_n(rst_n), .en(en_s),
    .pix_req(s_req), .pix_x(s_x), .pix_y(s_y), .frame_start(s_fs),
    .pix_data(pix_data_s),
    .lcd_de(s_de), .lcd_hsync(s_hs), .lcd_vsync(s_vs),
    .lcd_r(s_r), .lcd_g(s_g), .lcd_b(s_b)
  );

  // Upstream frame source: returns {x[5:0], y} during the cycle after the request
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pix_data = pd_next;
      pd_next  = {pix_x[5:0], pix_y};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit act_main(int t);
    return ((t % HT) < 480) && (((t / HT) % VT) < 272);
  endfunction

  function automatic bit hs_main(int t);
    return ((t % HT) >= 482) && ((t % HT) < 523);
  endfunction

  function automatic bit vs_main(int t);
    return (((t / HT) % VT) >= 274) && (((t / HT) % VT) < 284);
  endfunction

  function automatic logic [15:0] rgb_main(int t);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    if (!act_main(t)) return 16'h0;
`ifdef LCD_TEST_PATTERN_EN
    case (h / 60)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
`else
    return 16'(((h % 64) << 10) | v);
`endif
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync, rgb, pix_x, pix_y} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 10'h0, 10'h0}) begin
      errors++;
      $display("FAIL reset_main: req=%b fs=%b de=%b hs=%b vs=%b rgb=%h x=%0d y=%0d, need 0 0 0 1 1 0000 0 0",
               pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync, rgb, pix_x, pix_y);
    end
    checks++;
    if ({s_de, s_hs, s_vs} !== 3'b000) begin
      errors++;
      $display("FAIL reset_inverted_pol: de/hs/vs=%b need 000", {s_de, s_hs, s_vs});
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (100) tick();
    checks++;
    if ({lcd_de, pix_req} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_active: de/req=%b need 11", {lcd_de, pix_req});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync, rgb, pix_x, pix_y} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 10'h0, 10'h0}) begin
      errors++;
      $display("FAIL reset_midframe: req=%b fs=%b de=%b hs=%b vs=%b rgb=%h x=%0d y=%0d, need 0 0 0 1 1 0000 0 0",
               pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync, rgb, pix_x, pix_y);
    end
    en    = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    int mm = 0;
    int ft = -1;
    int hs_lo = 0;
    int de_n = 0;
    int fs_n = 0;
    logic [40:0] obs, exp_v;
    logic [40:0] fo = '0;
    logic [40:0] fe = '0;
    logic [9:0] ex = '0;
    logic [9:0] ey = '0;
    int h, v;
    bit a, a2;
    tick();
    en = 1'b1;
    for (int t = 0; t <= DROP_T; t++) begin
      tick();
      h  = t % HT;
      v  = (t / HT) % VT;
      a  = (h < 480) && (v < 272);
      if (a) begin
        ex = 10'(h);
        ey = 10'(v);
      end
      a2    = (t >= 2) && act_main(t - 2);
      exp_v = {a, (h == 0) && (v == 0), a2,
               !((t >= 2) && hs_main(t - 2)), !((t >= 2) && vs_main(t - 2)),
               (t >= 2) ? rgb_main(t - 2) : 16'h0, ex, ey};
      obs   = {pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync, rgb, pix_x, pix_y};
      if (obs !== exp_v) begin
        mm++;
        if (ft < 0) begin
          ft = t;
          fo = obs;
          fe = exp_v;
        end
      end
      fs_n += int'(frame_start);
      if (t >= 3 * HT + 2 && t < 4 * HT + 2) begin
        hs_lo += int'(!lcd_hsync);
        de_n  += int'(lcd_de);
      end
      if (t == 0) begin
        checks++;
        if ({frame_start, pix_req, pix_x, pix_y} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
          errors++;
          $display("FAIL first_request: fs/req/x/y=%b/%b/%0d/%0d need 1/1/0/0",
                   frame_start, pix_req, pix_x, pix_y);
        end
      end
      if (t == 1) begin
        checks++;
        if ({frame_start, lcd_de} !== 2'b00) begin
          errors++;
          $display("FAIL de_not_early: fs/de=%b need 00", {frame_start, lcd_de});
        end
      end
      if (t == 2) begin
        checks++;
        if ({lcd_de, rgb} !== {1'b1, RGB00}) begin
          errors++;
          $display("FAIL first_de: de=%b rgb=%h need 1 %h", lcd_de, rgb, RGB00);
        end
      end
      if (t == HT + 2) begin
        checks++;
        if (rgb !== P0) begin
          errors++;
          $display("FAIL rgb_x0: got %h need %h", rgb, P0);
        end
      end
      if (t == HT + 2 + 60) begin
        checks++;
        if (rgb !== P60) begin
          errors++;
          $display("FAIL rgb_x60: got %h need %h", rgb, P60);
        end
      end
      if (t == HT + 2 + 420) begin
        checks++;
        if (rgb !== P420) begin
          errors++;
          $display("FAIL rgb_x420: got %h need %h", rgb, P420);
        end
      end
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL free_run_model: %0d bad cycles, first t=%0d got %h need %h", mm, ft, fo, fe);
    end
    checks++;
    if (hs_lo !== 41) begin
      errors++;
      $display("FAIL hsync_width: got %0d need 41", hs_lo);
    end
    checks++;
    if (de_n !== 480) begin
      errors++;
      $display("FAIL de_per_line: got %0d need 480", de_n);
    end
    checks++;
    if (fs_n !== 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d need 1", fs_n);
    end
    checks++;
    if ({pix_x, pix_y} !== {10'd200, 10'd100}) begin
      errors++;
      $display("FAIL drop_point: x/y=%0d/%0d need 200/100", pix_x, pix_y);
    end
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    tick();
    checks++;
    if ({pix_req, lcd_de} !== 2'b01) begin
      errors++;
      $display("FAIL drop_edge1: req/de=%b need 01", {pix_req, lcd_de});
    end
    tick();
    checks++;
    if ({pix_req, lcd_de, rgb} !== {1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL drop_edge2: req/de=%b rgb=%h need 00 0000", {pix_req, lcd_de}, rgb);
    end
    repeat (5) tick();
    checks++;
    if ({pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync} !== 5'b00011) begin
      errors++;
      $display("FAIL idle_while_disabled: req/fs/de/hs/vs=%b need 00011",
               {pix_req, frame_start, lcd_de, lcd_hsync, lcd_vsync});
    end
    en = 1'b1;
    tick();
    checks++;
    if ({pix_req, frame_start, pix_x, pix_y} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL restart_origin: req/fs/x/y=%b/%b/%0d/%0d need 1/1/0/0",
               pix_req, frame_start, pix_x, pix_y);
    end
    tick();
    checks++;
    if ({frame_start, pix_x, lcd_de} !== {1'b0, 10'd1, 1'b0}) begin
      errors++;
      $display("FAIL restart_second: fs/x/de=%b/%0d/%b need 0/1/0", frame_start, pix_x, lcd_de);
    end
    tick();
    checks++;
    if ({lcd_de, rgb} !== {1'b1, RGB00}) begin
      errors++;
      $display("FAIL restart_first_de: de=%b rgb=%h need 1 %h", lcd_de, rgb, RGB00);
    end
  endtask

  task automatic test_inverted_polarity();
    int mm = 0;
    int ft = -1;
    int vs_hi = 0;
    int hs_hi = 0;
    int fs_t0 = -1;
    int fs_t1 = -1;
    logic [12:0] obs, exp_v;
    logic [12:0] fo = '0;
    logic [12:0] fe = '0;
    logic [3:0] ex = '0;
    logic [3:0] ey = '0;
    int h, v, h2, v2;
    bit a, a2, hs2, vs2;
    tick();
    en_s = 1'b1;
    for (int t = 0; t < 315; t++) begin
      tick();
      h  = t % 15;
      v  = (t / 15) % 7;
      a  = (h < 8) && (v < 3);
      if (a) begin
        ex = 4'(h);
        ey = 4'(v);
      end
      h2  = (t + 13) % 15;
      v2  = ((t + 103) / 15) % 7;
      a2  = (t >= 2) && (h2 < 8) && (v2 < 3);
      hs2 = (t >= 2) && (h2 >= 10) && (h2 < 13);
      vs2 = (t >= 2) && (v2 >= 4) && (v2 < 6);
      exp_v = {a, (h == 0) && (v == 0), a2, hs2, vs2, ex, ey};
      obs   = {s_req, s_fs, s_de, s_hs, s_vs, s_x, s_y};
      if (obs !== exp_v) begin
        mm++;
        if (ft < 0) begin
          ft = t;
          fo = obs;
          fe = exp_v;
        end
      end
      if (t >= 2 && t < 107) vs_hi += int'(s_vs);
      if (t >= 2 && t < 17)  hs_hi += int'(s_hs);
      if (s_fs === 1'b1) begin
        if (fs_t0 < 0) fs_t0 = t;
        else if (fs_t1 < 0) fs_t1 = t;
      end
    end
    checks++;
    if (mm !== 0) begin
      errors++;
      $display("FAIL small_model: %0d bad cycles, first t=%0d got %h need %h", mm, ft, fo, fe);
    end
    checks++;
    if (vs_hi !== 30) begin
      errors++;
      $display("FAIL small_vsync_width: got %0d need 30", vs_hi);
    end
    checks++;
    if (hs_hi !== 3) begin
      errors++;
      $display("FAIL small_hsync_width: got %0d need 3", hs_hi);
    end
    checks++;
    if (fs_t1 - fs_t0 !== 105) begin
      errors++;
      $display("FAIL small_frame_period: got %0d need 105", fs_t1 - fs_t0);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_en_drop();
    test_inverted_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
